// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline register between CPU stages, with    |
// |                  flush, back-pressure and a saturating stall counter.      |
// |                  Define SKID_BUF_EN to add a one-entry skid buffer.        |
// | Revision       : 1.0  initial release                                      |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int                DATA_W = 32,
  parameter int                PC_W   = 32,
  parameter logic [PC_W-1:0]   PC_RST = 32'h0000_3000,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_out_valid;
  logic [PC_W-1:0]   r_out_pc;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_out_xfer;
  logic w_accept;
  logic w_stall;
  logic w_cnt_sat;

  assign w_out_xfer = r_out_valid && out_ready;
  // Entries offered during a flush cycle are dropped, so they never count as accepted.
  assign w_accept   = in_valid && in_ready && !flush;
  assign w_stall    = in_valid && !in_ready && !flush;
  assign w_cnt_sat  = (r_stall_cnt == {CNT_W{1'b1}});

`ifdef SKID_BUF_EN
  logic              r_skid_valid;
  logic [PC_W-1:0]   r_skid_pc;
  logic [DATA_W-1:0] r_skid_data;

  // Registered ready: accepting only depends on skid occupancy, not on out_ready.
  assign in_ready = !r_skid_valid;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_out_valid  <= 1'b0;
      r_out_pc     <= PC_RST;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= PC_RST;
      r_skid_data  <= '0;
    end else if (w_out_xfer) begin
      if (r_skid_valid) begin
        r_out_pc     <= r_skid_pc;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_pc   <= in_pc;
        r_out_data <= in_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= in_pc;
        r_out_data  <= in_data;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_pc    <= in_pc;
        r_skid_data  <= in_data;
      end
    end
  end
`else
  assign in_ready = !r_out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= PC_RST;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= in_pc;
      r_out_data  <= in_data;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_data  = r_out_data;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
